// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts an N-bit word on a load/ready handshake and shifts it out one bit
// per clock on sout, qualified by sout_valid, followed by a one-cycle done
// pulse. Bit order is chosen by MSB_FIRST.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// (XOR of the captured word) as an extra serial cycle after the data bits.
// All outputs are registered.

module piso_tx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  // Counter must be able to hold N, the index of the parity cycle.
  localparam int CW = (N + 1 > 1) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
`ifdef PISO_TX_PARITY_EN
  localparam logic [CW-1:0] PAR_IDX = CW'(N);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   shift_reg;
  logic [CW-1:0]  bit_cnt;
`ifdef PISO_TX_PARITY_EN
  logic           parity_bit;
`endif

  // Control FSM, shift register, bit counter and registered outputs.
  // The first bit is driven on the capture edge itself so it appears one
  // cycle after the load edge; shift_reg then holds the remaining bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ready      <= 1'b1;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready      <= 1'b1;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
          if (load) begin
            ready      <= 1'b0;
            sout_valid <= 1'b1;
            bit_cnt    <= '0;
            state      <= SHIFT;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= ^din;
`endif
            if (MSB_FIRST) begin
              sout      <= din[N-1];
              shift_reg <= din << 1;
            end else begin
              sout      <= din[0];
              shift_reg <= din >> 1;
            end
          end
        end

        SHIFT: begin
`ifdef PISO_TX_PARITY_EN
          if (bit_cnt == PAR_IDX) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (bit_cnt == LAST_BIT) begin
            sout       <= parity_bit;
            sout_valid <= 1'b1;
            bit_cnt    <= bit_cnt + 1'b1;
          end else begin
            sout_valid <= 1'b1;
            bit_cnt    <= bit_cnt + 1'b1;
            if (MSB_FIRST) begin
              sout      <= shift_reg[N-1];
              shift_reg <= shift_reg << 1;
            end else begin
              sout      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
`else
          if (bit_cnt == LAST_BIT) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            sout_valid <= 1'b1;
            bit_cnt    <= bit_cnt + 1'b1;
            if (MSB_FIRST) begin
              sout      <= shift_reg[N-1];
              shift_reg <= shift_reg << 1;
            end else begin
              sout      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
`endif
        end

        DONE: begin
          done       <= 1'b0;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          ready      <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state      <= IDLE;
          ready      <= 1'b1;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
